// File: rtl/qr_givens_sequencer_pkg.sv
// Shared constants, state encoding and op payload type for the Givens QR sequencer.
package qr_givens_sequencer_pkg;

    localparam int unsigned N_DEF       = 6;
    localparam int unsigned IDX_W_DEF   = 3;
    localparam int unsigned MAX_OUT_DEF = 4;
    localparam int unsigned NUM_PAIRS   = N_DEF * (N_DEF - 1) / 2;

    typedef enum logic [2:0] {
        IDLE,
        VEC_ISSUE,
        VEC_WAIT,
        ROT_ISSUE,
        DRAIN,
        DONE
    } state_t;

    // One rotation op as seen on the datapath interface.
    typedef struct packed {
        logic                 vec;
        logic [IDX_W_DEF-1:0] i;
        logic [IDX_W_DEF-1:0] j;
        logic [IDX_W_DEF-1:0] k;
    } op_t;

endpackage

// File: rtl/qr_givens_sequencer_pair_index_gen.sv
// (i, j, k) index counters for the Givens sweep: pairs in row-major upper
// triangle order, rotation columns ascending with the pivot column skipped.
module qr_pair_index_gen
    import qr_givens_sequencer_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_k_first,
    input  logic             i_k_adv,
    input  logic             i_pair_adv,
    output logic [IDX_W-1:0] o_i,
    output logic [IDX_W-1:0] o_j,
    output logic [IDX_W-1:0] o_k,
    output logic             o_last_k_c,
    output logic             o_last_pair_c
);

    localparam int unsigned CW = IDX_W + 1;

    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic [IDX_W-1:0] r_k;
    logic [CW-1:0]    w_k_inc;
    logic [CW-1:0]    w_k_step;

    // Next rotation column: k+1, hopping over the pivot column i.
    always_comb begin
        w_k_inc  = CW'(r_k) + CW'(1);
        w_k_step = w_k_inc;
        if (w_k_inc == CW'(r_i)) begin
            w_k_step = w_k_inc + CW'(1);
        end
    end

    assign o_last_k_c    = (w_k_step >= CW'(N));
    assign o_last_pair_c = (r_i == IDX_W'(N - 2)) && (r_j == IDX_W'(N - 1));
    assign o_i           = r_i;
    assign o_j           = r_j;
    assign o_k           = r_k;

    // Counter update; a pair advance points k at the new pivot for the vectoring op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_load) begin
            r_i <= '0;
            r_j <= IDX_W'(1);
            r_k <= '0;
        end else if (i_pair_adv) begin
            if (r_j == IDX_W'(N - 1)) begin
                r_i <= r_i + IDX_W'(1);
                r_j <= r_i + IDX_W'(2);
                r_k <= r_i + IDX_W'(1);
            end else begin
                r_j <= r_j + IDX_W'(1);
                r_k <= r_i;
            end
        end else if (i_k_first) begin
            r_k <= (r_i == '0) ? IDX_W'(1) : '0;
        end else if (i_k_adv) begin
            r_k <= w_k_step[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/qr_givens_sequencer.sv
// Sequencer for a shared Givens-rotation datapath over a full NxN QR sweep:
// issues one (i,j,k) op per cycle, tracks ops in flight and enforces the
// angle-before-rotate and pair-to-pair hazards.
module qr_givens_sequencer
    import qr_givens_sequencer_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF,
    parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             op_vec,
    output logic [IDX_W-1:0] op_i,
    output logic [IDX_W-1:0] op_j,
    output logic [IDX_W-1:0] op_k,
    input  logic             wb_valid,
    output logic             err
);

    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [OUT_W-1:0] r_outstanding;
    logic [OUT_W-1:0] w_out_next;
    logic             r_busy;
    logic             r_done;
    logic             r_op_valid;
    logic             r_op_vec;
    logic             r_err;
    logic             w_busy_next;
    logic             w_done_next;
    logic             w_valid_next;
    logic             w_vec_next;
    logic             w_err_next;
    logic             w_accept;
    logic             w_load;
    logic             w_k_first;
    logic             w_k_adv;
    logic             w_pair_adv;
    logic             w_last_k;
    logic             w_last_pair;
    logic             w_full;

    assign w_accept = r_op_valid & op_ready;
    assign w_full   = (r_outstanding == OUT_W'(MAX_OUT));

    qr_pair_index_gen #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_load),
        .i_k_first     (w_k_first),
        .i_k_adv       (w_k_adv),
        .i_pair_adv    (w_pair_adv),
        .o_i           (op_i),
        .o_j           (op_j),
        .o_k           (op_k),
        .o_last_k_c    (w_last_k),
        .o_last_pair_c (w_last_pair)
    );

    // Ops in flight: +1 on accept, -1 on retire; wiped on abort and in IDLE.
    always_comb begin
        w_out_next = r_outstanding;
        if (abort || (r_state == IDLE)) begin
            w_out_next = '0;
        end else if (w_accept && !wb_valid) begin
            if (!w_full) begin
                w_out_next = r_outstanding + OUT_W'(1);
            end
        end else if (!w_accept && wb_valid) begin
            if (r_outstanding != '0) begin
                w_out_next = r_outstanding - OUT_W'(1);
            end
        end
    end

    // Sticky protocol error: retire with nothing in flight, or accept when full.
    always_comb begin
        w_err_next = r_err;
        if (r_state != IDLE) begin
            if ((wb_valid && (r_outstanding == '0) && !w_accept) || (w_accept && w_full)) begin
                w_err_next = 1'b1;
            end
        end
    end

    // Next state, index-counter strobes and registered output values.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_k_first    = 1'b0;
        w_k_adv      = 1'b0;
        w_pair_adv   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = VEC_ISSUE;
                    w_load       = 1'b1;
                end
            end
            VEC_ISSUE: begin
                if (w_accept) begin
                    w_state_next = VEC_WAIT;
                end
            end
            VEC_WAIT: begin
                if (wb_valid) begin
                    w_state_next = ROT_ISSUE;
                    w_k_first    = 1'b1;
                end
            end
            ROT_ISSUE: begin
                if (w_accept) begin
                    if (w_last_k) begin
                        w_state_next = DRAIN;
                    end else begin
                        w_k_adv = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (w_out_next == '0) begin
                    if (w_last_pair) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = VEC_ISSUE;
                        w_pair_adv   = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (abort) begin
            w_state_next = IDLE;
            w_load       = 1'b0;
            w_k_first    = 1'b0;
            w_k_adv      = 1'b0;
            w_pair_adv   = 1'b0;
        end

        w_valid_next = ((w_state_next == VEC_ISSUE) || (w_state_next == ROT_ISSUE))
                       && (w_out_next < OUT_W'(MAX_OUT));
        w_vec_next   = (w_state_next == VEC_ISSUE);
        w_busy_next  = (w_state_next != IDLE);
        w_done_next  = (r_state == DONE) && !abort;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_outstanding <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_op_valid    <= 1'b0;
            r_op_vec      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_out_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_op_valid    <= w_valid_next;
            r_op_vec      <= w_vec_next;
            r_err         <= w_err_next;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign op_valid = r_op_valid;
    assign op_vec   = r_op_vec;
    assign err      = r_err;

endmodule

// File: doc/qr_givens_sequencer.md
Name: qr_givens_sequencer

Overview:
- Controller that sequences a shared Givens-rotation datapath (CORDIC vectoring/rotation pair plus H / Q_T register banks) through a full N×N real QR decomposition.
- Emits one rotation op per cycle as an (i, j, k) index triple over a valid/ready handshake.
- Tracks ops in flight in the pipelined datapath.
- Enforces the two data hazards: angle-before-rotate, and pair-to-pair row reuse.
- Sits between the MIMO detector control FSM (start/done) and the rotation datapath.

Parameters:
- N, 6, matrix dimension (real-expanded 3×3 complex channel).
- IDX_W, 3, index width; must satisfy 2^IDX_W ≥ N.
- MAX_OUT, 4, maximum ops in flight in the datapath pipeline.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  pulse; begin a decomposition. Ignored while busy=1.
- abort  in  1  synchronous cancel of the current decomposition.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when all pairs are fully written back.
- op_valid  out  1  op triple valid.
- op_ready  in  1  datapath accepts the op this cycle.
- op_vec  out  1  1 = vectoring op (angle capture, k==i); 0 = rotation op.
- op_i  out  IDX_W  pivot row.
- op_j  out  IDX_W  target row.
- op_k  out  IDX_W  column.
- wb_valid  in  1  datapath retired one op (in issue order).
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: busy=0, done=0, op_valid=0, op_vec=0, op_i/j/k=0, err=0, outstanding=0, state=IDLE. All outputs are registered.
- Pair order: i = 0..N-2, and for each i, j = i+1..N-1. This gives N(N-1)/2 pairs (15 at N=6).
- Per pair:
  - The first op is op_vec=1 with k=i.
  - It is followed by N-1 rotation ops with k ascending over 0..N-1, skipping i.
- States:
  - IDLE: on start, go to VEC_ISSUE with i=0, j=1.
  - VEC_ISSUE: op_valid=1, op_vec=1. On op_valid&&op_ready, go to VEC_WAIT.
  - VEC_WAIT: op_valid=0. The angle is valid only after the vectoring op retires. On wb_valid, go to ROT_ISSUE.
  - ROT_ISSUE: issue the rotation ops back to back while op_ready=1 and outstanding<MAX_OUT. After the last accepted op, go to DRAIN.
  - DRAIN: wait for outstanding_next==0, which includes a same-cycle wb_valid. Then either advance (i,j) and go to VEC_ISSUE, or, after the final pair, go to DONE.
  - DONE: done=1 for one cycle, busy drops, then IDLE.
- Handshake:
  - While op_valid=1 and op_ready=0, op_vec/op_i/op_j/op_k hold stable.
  - op_valid is forced to 0 when outstanding==MAX_OUT.
- Outstanding counter:
  - +1 on accept, -1 on wb_valid.
  - A simultaneous accept and wb_valid leaves it unchanged.
  - Width is clog2(MAX_OUT+1).
- err is set and sticky on:
  - wb_valid with outstanding==0 and no same-cycle accept, or
  - any accept while outstanding==MAX_OUT.
  - err clears only on reset.
- abort:
  - Next state is IDLE; op_valid and busy drop the next cycle.
  - outstanding is cleared; late wb_valid in IDLE is ignored (not an error).
  - No done pulse. abort takes priority over start and over any in-progress transition.
- start in the same cycle as done: ignored; start is sampled only in IDLE.
- Timing: with op_ready=1 and 1-cycle datapath latency, each pair takes 8 cycles. done is asserted 121 cycles after the start-sampling edge (N=6).
- rst_n asserted mid-operation: immediate return to the reset values.

Decomposition:
- Shared package holds:
  - N, IDX_W, MAX_OUT defaults.
  - The state encoding (IDLE, VEC_ISSUE, VEC_WAIT, ROT_ISSUE, DRAIN, DONE).
  - The NUM_PAIRS constant, N*(N-1)/2.
- One sub-module, qr_pair_index_gen:
  - Holds the (i,j,k) counters, the k-skip-i logic, and the last_k / last_pair flags.
  - Advance inputs come from the FSM.
- The FSM and outstanding counter stay in the top.

Test Plan:
- Nominal run, op_ready=1, 1-cycle wb model: 90 ops accepted in pair order. The first four triples are (vec,0,1,0), (rot,0,1,1), (rot,0,1,2), (rot,0,1,3). The last triple is (rot,4,5,5). done pulses exactly once, 121 cycles after start. err=0.
- Angle hazard: wb latency 3 cycles. After each vec accept there are no rotation ops until its wb_valid. op_valid stays low for 3 cycles per pair.
- Backpressure: op_ready toggles 1,0,0,1 repeatedly. The triple is stable while stalled, there are no duplicate or skipped ops, and the op total is 90.
- MAX_OUT limit: wb latency 6, MAX_OUT=4. outstanding never exceeds 4, and op_valid deasserts when it reaches 4.
- Abort at pair 7: busy=0 and op_valid=0 one cycle later, with no done. Stray wb_valid in IDLE gives err=0. A following start completes normally with 90 ops.
- Protocol error: wb_valid injected in ROT_ISSUE with outstanding=0 sets err=1, and err stays 1 until rst_n=0.
